window_buffer: RTL

//  Upstream neighbour of the intensity stage. Accepts a raster-order stream of
//  24-bit RGB pixels, keeps the two previous image rows in on-chip line buffers,
//  and emits one registered 3x3 RGB neighbourhood (216 bits) per accepted pixel

---
 rtl/window_buffer.sv | 119 +++++++++++
 1 files changed

// File: rtl/window_buffer.sv
// 3x3 RGB neighbourhood generator: two line buffers plus column history feed a
// registered 216-bit window per accepted pixel. Optional macro: FRAME_DONE_EN.
module window_buffer #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic [23:0]  pixel_in,
    input  logic         pixel_valid,
    input  logic         frame_start,
    output logic [215:0] pixelData,
    output logic         window_valid
`ifdef FRAME_DONE_EN
    ,
    output logic         frame_done
`endif
);
    // Handshake: pixel_in is taken on any posedge where accept is high; there is
    // no back-pressure, and window_valid is a one-cycle strobe qualifying pixelData.
    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);

    logic [CW-1:0] col, col_nxt, cur_col;
    logic [RW-1:0] row, row_nxt, cur_row;
    logic          accept;
    logic          in_window;

    logic [23:0] lb1 [WIDTH];
    logic [23:0] lb2 [WIDTH];
    logic [23:0] top_col, mid_col;

    // Index 0 holds column c-1, index 1 holds column c-2.
    logic [1:0][23:0] top_sr, mid_sr, bot_sr;

    assign cur_col = frame_start ? '0 : col;
    assign cur_row = frame_start ? '0 : row;

`ifdef FRAME_DONE_EN
    logic hold;
    logic last_pix;

    // After the last pixel of a frame, only a frame_start pixel is taken.
    assign accept   = pixel_valid && (!hold || frame_start);
    assign last_pix = accept && (cur_col == CW'(WIDTH - 1)) && (cur_row == RW'(HEIGHT - 1));

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            hold       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= last_pix;
            if (last_pix)
                hold <= 1'b1;
            else if (frame_start)
                hold <= 1'b0;
        end
    end
`else
    assign accept = pixel_valid;
`endif

    always_comb begin
        col_nxt = col;
        row_nxt = row;
        if (accept) begin
            if (cur_col == CW'(WIDTH - 1)) begin
                col_nxt = '0;
                row_nxt = (cur_row == RW'(HEIGHT - 1)) ? '0 : cur_row + RW'(1);
            end else begin
                col_nxt = cur_col + CW'(1);
                row_nxt = cur_row;
            end
        end else if (frame_start) begin
            col_nxt = '0;
            row_nxt = '0;
        end
    end

    assign top_col   = lb2[cur_col];
    assign mid_col   = lb1[cur_col];
    assign in_window = (cur_row >= RW'(2)) && (cur_col >= CW'(2));

    // Line-buffer RAM is deliberately not reset; the row gate hides stale data.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[cur_col] <= pixel_in;
            lb2[cur_col] <= lb1[cur_col];
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            col          <= '0;
            row          <= '0;
            top_sr       <= '0;
            mid_sr       <= '0;
            bot_sr       <= '0;
            pixelData    <= '0;
            window_valid <= 1'b0;
        end else begin
            col          <= col_nxt;
            row          <= row_nxt;
            window_valid <= 1'b0;
            if (accept) begin
                top_sr <= {top_sr[0], top_col};
                mid_sr <= {mid_sr[0], mid_col};
                bot_sr <= {bot_sr[0], pixel_in};
                if (in_window) begin
                    pixelData    <= {top_sr[1], top_sr[0], top_col,
                                     mid_sr[1], mid_sr[0], mid_col,
                                     bot_sr[1], bot_sr[0], pixel_in};
                    window_valid <= 1'b1;
                end
            end
        end
    end

endmodule
